// File: rtl/apb_arbiter_if.sv
// apb_arbiter_if
//   Bundles the signals around the two-requester APB arbiter.
//   Requester side: req/addr/wdata/wr/dsize in, done/err/rdata out (x2).
//   APB side: psel/penable/pwrite/paddr/pwdata/pstrb out, prdata/pready/pslverr in.
//   owner: index of the current or last granted requester.
//   modport master : the arbiter (it masters the APB port).
//   modport slave  : the environment (requesters plus APB slave).
interface apb_arbiter_if;
  logic        req0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        wr0;
  logic [3:0]  dsize0;
  logic        done0;
  logic        err0;
  logic [31:0] rdata0;

  logic        req1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        wr1;
  logic [3:0]  dsize1;
  logic        done1;
  logic        err1;
  logic [31:0] rdata1;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        owner;

  modport master (
    input  req0, addr0, wdata0, wr0, dsize0,
    output done0, err0, rdata0,
    input  req1, addr1, wdata1, wr1, dsize1,
    output done1, err1, rdata1,
    output psel, penable, pwrite, paddr, pwdata, pstrb, owner,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req0, addr0, wdata0, wr0, dsize0,
    input  done0, err0, rdata0,
    output req1, addr1, wdata1, wr1, dsize1,
    input  done1, err1, rdata1,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, owner,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_arbiter.sv
// apb_arbiter
//   Round-robin arbiter and APB SETUP/ACCESS sequencer for two requesters
//   (0: core load/store/fetch, 1: debug/DMA) sharing one APB master port.
//   A bounded wait-state timeout forces an error completion when the slave
//   holds pready low for TIMEOUT ACCESS cycles (TIMEOUT=0 disables it).
//   Ports:
//     clk : system clock, rising edge
//     rts : asynchronous active-high reset
//     bus : apb_arbiter_if.master, requester and APB signals
//   Parameters:
//     TO_BITS : width of the wait-state counter (must hold TIMEOUT-1)
//     TIMEOUT : ACCESS cycles allowed with pready low, 0 = no timeout
module apb_arbiter #(
  parameter int unsigned TO_BITS = 10,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic           clk,
  input logic           rts,
  apb_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_EN ? TO_BITS'(TIMEOUT - 1) : '0;
  localparam logic [TO_BITS-1:0] CNT_MAX = '1;

  state_e              state_q;
  logic [TO_BITS-1:0]  cnt_q;
  logic                last_q;
  logic                owner_q;
  logic                psel_q, penable_q, pwrite_q;
  logic [31:0]         paddr_q, pwdata_q;
  logic [3:0]          pstrb_q;
  logic                done0_q, done1_q, err0_q, err1_q;
  logic [31:0]         rdata0_q, rdata1_q;

  logic                elig0, elig1;
  logic                grant_d;
  logic [31:0]         addr_d, wdata_d;
  logic                wr_d;
  logic [3:0]          dsize_d;
  logic                timeout_hit;
  logic                cpl_err_d;
  logic [31:0]         cpl_rdata_d;
  logic [TO_BITS-1:0]  cnt_d;

  // A requester is masked during its own done cycle so a held req re-issues
  // one cycle later instead of being granted twice for one transfer.
  assign elig0   = bus.req0 & ~done0_q;
  assign elig1   = bus.req1 & ~done1_q;
  assign grant_d = (elig0 & elig1) ? ~last_q : elig1;

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);
  // Timeout completions always report an error with zero data; writes
  // return zero data on a normal completion too.
  assign cpl_err_d   = bus.pready ? bus.pslverr : 1'b1;
  assign cpl_rdata_d = (bus.pready && !pwrite_q) ? bus.prdata : '0;
  // Saturate rather than wrap so a disabled timeout never aliases back to 0.
  assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_BITS'(1);

  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    addr_d  = bus.addr0;
    wdata_d = bus.wdata0;
    wr_d    = bus.wr0;
    dsize_d = bus.dsize0;
    if (grant_d) begin
      addr_d  = bus.addr1;
      wdata_d = bus.wdata1;
      wr_d    = bus.wr1;
      dsize_d = bus.dsize1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      // NOTE: data registers are reset as well, because every output must
      // read 0 while rts is high; last_q=1 hands the first tie to requester 0.
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (elig0 || elig1) begin
            paddr_q   <= addr_d;
            pwdata_q  <= wdata_d;
            pwrite_q  <= wr_d;
            pstrb_q   <= dsize_d;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            owner_q   <= grant_d;
            last_q    <= grant_d;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready || timeout_hit) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
            if (owner_q) begin
              done1_q  <= 1'b1;
              err1_q   <= cpl_err_d;
              rdata1_q <= cpl_rdata_d;
            end else begin
              done0_q  <= 1'b1;
              err0_q   <= cpl_err_d;
              rdata0_q <= cpl_rdata_d;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pstrb   = pstrb_q;
  assign bus.owner   = owner_q;
  assign bus.done0   = done0_q;
  assign bus.err0    = err0_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.done1   = done1_q;
  assign bus.err1    = err1_q;
  assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter
//   Self-checking bench for apb_arbiter (TIMEOUT=4). A table of per-cycle
//   vectors covers reset, a single read and two-way contention; hand-written
//   sequences cover wait states with slave error, timeout, and reset in the
//   middle of an ACCESS phase.
module tb_apb_arbiter;

  logic clk = 1'b0;
  logic rts = 1'b1;
  apb_arbiter_if bus ();

  apb_arbiter #(.TO_BITS(10), .TIMEOUT(4)) dut (
    .clk (clk),
    .rts (rts),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst;
    logic        req0;
    logic        req1;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        e_psel;
    logic        e_penable;
    logic        e_pwrite;
    logic        e_owner;
    logic        e_done0;
    logic        e_done1;
    logic        e_err0;
    logic        e_err1;
    logic [31:0] e_rdata0;
    logic [31:0] e_rdata1;
    logic [31:0] e_paddr;
  } vec_t;

  localparam logic [31:0] A = 32'h0000_0100;
  localparam logic [31:0] B = 32'h2000_0004;
  localparam logic [31:0] D = 32'hDEAD_BEEF;
  localparam logic [31:0] P = 32'h1234_5678;
  localparam logic [31:0] C = 32'hCAFE_F00D;

  vec_t vec [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;

    bus.req0 = 1'b0; bus.addr0 = A; bus.wdata0 = 32'hA0A0_A0A0; bus.wr0 = 1'b0; bus.dsize0 = 4'b1111;
    bus.req1 = 1'b0; bus.addr1 = B; bus.wdata1 = 32'h0000_0077; bus.wr1 = 1'b0; bus.dsize1 = 4'b0011;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;

    //            rst req0 req1 rdy err prdata  psel pen  pwr  own  d0   d1   e0   e1   rdata0 rdata1 paddr
    vec[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0};
    vec[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,D,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,A};
    vec[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,D,     1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,A};
    vec[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,D,     1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,D,    32'h0,A};
    vec[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,D,     1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,D,    32'h0,A};
    vec[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0};
    vec[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,P,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,A};
    vec[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,P,     1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,A};
    vec[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,P,     1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,P,    32'h0,A};
    vec[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,P,     1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,P,    32'h0,B};
    vec[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,P,     1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,P,    32'h0,B};
    vec[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,P,     1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,P,    P,    B};
    vec[12] = '{1'b0,1'b1,1'b1,1'b1,1'b0,C,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P,    P,    A};
    vec[13] = '{1'b0,1'b1,1'b1,1'b1,1'b0,C,     1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P,    P,    A};
    vec[14] = '{1'b0,1'b1,1'b1,1'b1,1'b0,C,     1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,C,    P,    A};
    vec[15] = '{1'b0,1'b1,1'b1,1'b1,1'b0,C,     1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,C,    P,    B};
    // Both requests dropped after grant: requester 1's transfer still completes.
    vec[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,C,     1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,C,    P,    B};
    vec[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0,C,     1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,C,    C,    B};
    vec[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0,C,     1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,C,    C,    B};

    #2;
    for (int i = 0; i < 19; i++) begin
      rts         = vec[i].rst;
      bus.req0    = vec[i].req0;
      bus.req1    = vec[i].req1;
      bus.pready  = vec[i].pready;
      bus.pslverr = vec[i].pslverr;
      bus.prdata  = vec[i].prdata;
      step();
      check($sformatf("row%0d psel", i),    32'(bus.psel),    32'(vec[i].e_psel));
      check($sformatf("row%0d penable", i), 32'(bus.penable), 32'(vec[i].e_penable));
      check($sformatf("row%0d pwrite", i),  32'(bus.pwrite),  32'(vec[i].e_pwrite));
      check($sformatf("row%0d owner", i),   32'(bus.owner),   32'(vec[i].e_owner));
      check($sformatf("row%0d done0", i),   32'(bus.done0),   32'(vec[i].e_done0));
      check($sformatf("row%0d done1", i),   32'(bus.done1),   32'(vec[i].e_done1));
      check($sformatf("row%0d err0", i),    32'(bus.err0),    32'(vec[i].e_err0));
      check($sformatf("row%0d err1", i),    32'(bus.err1),    32'(vec[i].e_err1));
      check($sformatf("row%0d rdata0", i),  bus.rdata0,       vec[i].e_rdata0);
      check($sformatf("row%0d rdata1", i),  bus.rdata1,       vec[i].e_rdata1);
      check($sformatf("row%0d paddr", i),   bus.paddr,        vec[i].e_paddr);
      if (i == 1) check("row1 pstrb", 32'(bus.pstrb), 32'h0000_000F);
    end

    // Wait states then slave error on a byte write from requester 1.
    bus.addr1 = B; bus.wdata1 = 32'h0000_0055; bus.wr1 = 1'b1; bus.dsize1 = 4'b0001;
    bus.req1 = 1'b1; bus.pready = 1'b0; bus.pslverr = 1'b0;
    step();
    check("wr grant psel",   32'(bus.psel),   32'h1);
    check("wr grant owner",  32'(bus.owner),  32'h1);
    check("wr grant pwrite", 32'(bus.pwrite), 32'h1);
    check("wr grant pwdata", bus.pwdata,      32'h0000_0055);
    check("wr grant pstrb",  32'(bus.pstrb),  32'h0000_0001);
    step();
    check("wr setup penable", 32'(bus.penable), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("wr wait%0d psel", k),  32'(bus.psel),  32'h1);
      check($sformatf("wr wait%0d done1", k), 32'(bus.done1), 32'h0);
    end
    bus.pready = 1'b1; bus.pslverr = 1'b1;
    step();
    check("wr cpl psel",   32'(bus.psel),  32'h0);
    check("wr cpl done1",  32'(bus.done1), 32'h1);
    check("wr cpl err1",   32'(bus.err1),  32'h1);
    check("wr cpl rdata1", bus.rdata1,     32'h0);
    check("wr cpl done0",  32'(bus.done0), 32'h0);
    bus.req1 = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    step();
    check("wr after done1", 32'(bus.done1), 32'h0);
    check("wr after err1",  32'(bus.err1),  32'h0);

    // Timeout: slave never ready, four ACCESS cycles then forced error.
    bus.addr0 = 32'h0000_0300; bus.wr0 = 1'b0; bus.req0 = 1'b1;
    bus.prdata = 32'hFFFF_FFFF;
    step();
    check("to grant owner", 32'(bus.owner), 32'h0);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("to access%0d psel", k), 32'(bus.psel), 32'h1);
    end
    step();
    check("to psel",    32'(bus.psel),    32'h0);
    check("to penable", 32'(bus.penable), 32'h0);
    check("to done0",   32'(bus.done0),   32'h1);
    check("to err0",    32'(bus.err0),    32'h1);
    check("to rdata0",  bus.rdata0,       32'h0);
    bus.req0 = 1'b0;
    step();

    // A later request after the timeout runs at minimum latency.
    bus.req0 = 1'b1; bus.pready = 1'b1; bus.prdata = 32'h0BAD_CAFE;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.done0 && cyc < 10);
    check("post-to latency", 32'(cyc),        32'd3);
    check("post-to done0",   32'(bus.done0),  32'h1);
    check("post-to err0",    32'(bus.err0),   32'h0);
    check("post-to rdata0",  bus.rdata0,      32'h0BAD_CAFE);
    bus.req0 = 1'b0;
    step();

    // Reset in the middle of ACCESS abandons the transfer.
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.pready = 1'b0;
    step();
    check("rst pre owner", 32'(bus.owner), 32'h1);
    step();
    step();
    check("rst pre psel", 32'(bus.psel), 32'h1);
    #3;
    rts = 1'b1;
    #1;
    check("rst async psel",    32'(bus.psel),    32'h0);
    check("rst async penable", 32'(bus.penable), 32'h0);
    check("rst async done0",   32'(bus.done0),   32'h0);
    check("rst async done1",   32'(bus.done1),   32'h0);
    check("rst async owner",   32'(bus.owner),   32'h0);
    step();
    check("rst held done1", 32'(bus.done1), 32'h0);
    rts = 1'b0; bus.pready = 1'b1; bus.prdata = 32'h5A5A_0001;
    step();
    check("rst regrant psel",  32'(bus.psel),  32'h1);
    check("rst regrant owner", 32'(bus.owner), 32'h0);
    check("rst regrant paddr", bus.paddr,      32'h0000_0300);
    step();
    step();
    check("rst regrant done0",  32'(bus.done0), 32'h1);
    check("rst regrant done1",  32'(bus.done1), 32'h0);
    check("rst regrant rdata0", bus.rdata0,     32'h5A5A_0001);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared APB master port.
- Requester 0 is the core load/store/fetch path. Requester 1 is a debug/DMA agent.
- Grants the bus round-robin, drives the APB SETUP/ACCESS phases, and enforces a bounded wait-state timeout.
- Returns read data, error and a one-cycle done pulse to the owning requester; sits between the requesters and the APB bus module.

Parameters:
- TO_BITS, 10, width of the wait-state timeout counter.
- TIMEOUT, 1000, ACCESS-phase cycles allowed with pready low before forced error termination; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- rts  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 transfer request
- addr0  in  32  requester 0 address
- wdata0  in  32  requester 0 write data
- wr0  in  1  requester 0 write (1) / read (0)
- dsize0  in  4  requester 0 byte lanes (0001 byte, 0011 half, 1111 word)
- done0  out  1  requester 0 completion pulse
- err0  out  1  requester 0 error, valid with done0
- rdata0  out  32  requester 0 read data, valid with done0
- req1, addr1, wdata1, wr1, dsize1, done1, err1, rdata1: same as above, for requester 1
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB write
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- pstrb  out  4  APB byte lanes, copied from dsize
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error
- owner  out  1  index of current or last granted requester

Behaviour:
- Reset: clk is the single clock; rts is asynchronous, active-high.
  - While rts=1, every output is 0 immediately.
  - FSM goes to IDLE; timeout counter = 0; internal last-grant register = 1, so requester 0 wins the first contention. The owner output is 0 in reset.
  - Reset mid-transfer abandons the transfer: no done is issued and psel drops asynchronously.
- FSM states are IDLE, SETUP and ACCESS. All outputs are registered.
- IDLE:
  - A requester is eligible if req_i=1 and done_i=0 in that cycle. A requester holding req high through its done cycle therefore re-issues one cycle later.
  - If exactly one requester is eligible, grant it.
  - If both are eligible, grant the one not equal to last-grant.
  - On grant, capture addr/wdata/wr/dsize into paddr/pwdata/pwrite/pstrb, set psel=1, penable=0, owner=grant, update last-grant, and go to SETUP.
- SETUP (exactly 1 cycle): set penable=1, clear the timeout counter, go to ACCESS.
- ACCESS:
  - pready=1 at the edge: set psel=0 and penable=0 and return to IDLE.
    - For a read, rdata_owner = prdata; for a write, rdata_owner = 0.
    - err_owner = pslverr; done_owner = 1 for the next cycle only.
  - pready=0: the counter increments.
    - If TIMEOUT!=0 and counter == TIMEOUT-1 at that edge, terminate as above with err_owner=1 and rdata_owner=0.
  - Minimum transfer: grant edge to done is 3 cycles (SETUP, ACCESS, done cycle in IDLE).
- Requester-side rules:
  - A requester keeps req and its operands stable from assertion until done. The arbiter samples operands only at grant.
  - Dropping req after grant does not cancel the transfer.
- Non-owning requester outputs:
  - done/err for the non-owner are always 0.
  - rdata_i holds its last value until its next completion. Only the owner's rdata is updated at done.
- Back-to-back operation: with both requesters requesting continuously, grants alternate 0,1,0,1 with one IDLE cycle between transfers.
- pslverr is sampled only on the completing edge (pready=1); ignored otherwise.
- Counter width TO_BITS must hold TIMEOUT-1; a counter at its maximum value does not wrap.

Test Plan:
- Single read: req0=1, addr0=0x0000_0100, wr0=0, dsize0=1111; slave pready=1 first ACCESS cycle, prdata=0xDEADBEEF -> psel high 2 cycles (penable on 2nd), paddr=0x100, pwrite=0, pstrb=1111; then done0 pulse 1 cycle with rdata0=0xDEADBEEF, err0=0, done1=0.
- Contention: req0 and req1 asserted in the same cycle after reset, held -> grant order 0,1,0,1; owner toggles; each done on the correct port; one IDLE cycle between psel pulses.
- Wait states and error: write addr1=0x2000_0004, wdata1=0x55, dsize1=0001; pready low 3 cycles then high with pslverr=1 -> pwdata=0x55, pstrb=0001, ACCESS lasts 4 cycles, done1 with err1=1.
- Timeout (TIMEOUT=4): pready held 0 -> after 4 ACCESS cycles psel/penable drop, done0=1, err0=1, rdata0=0; a later request proceeds normally.
- Reset mid-ACCESS: assert rts during ACCESS with pready low -> psel, penable and all done outputs 0 immediately with no done pulse; after release, the next contention grants requester 0 first.
